// File: rtl/split_sample_gen.sv
// Candidate generator for a split_N constraint checker: proposes Galois-LFSR values one
// per cycle and hands the first value the checker accepts out through a valid/ready port.
module split_sample_gen #(
    parameter int               WIDTH     = 13,
    parameter logic [WIDTH-1:0] SEED      = 13'h0001,
    parameter logic [WIDTH-1:0] TAPS      = 13'h100D,
    parameter int               MAX_TRIES = 64,
    localparam int              TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] cand,
    output logic             cand_valid,
    input  logic             chk_sat,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fail,
    output logic             busy,
    output logic [TW-1:0]    tries
);

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [TW-1:0]    TRIES_MAX = TW'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROPOSE,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             fail_q, fail_d;
    logic [TW-1:0]    tries_inc;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? TAPS : '0);
    endfunction

    assign tries_inc = tries_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        out_data_d = out_data_q;
        tries_d    = tries_q;
        fail_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tries_d = '0;
                    state_d = ST_PROPOSE;
                end
            end
            ST_PROPOSE: begin
                tries_d = tries_inc;
                if (chk_sat) begin
                    // Keep the accepted value in the LFSR; it advances on hand-off.
                    out_data_d = lfsr_q;
                    state_d    = ST_HOLD;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (tries_inc == TRIES_MAX) begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED_INIT;
            out_data_q <= '0;
            tries_q    <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            out_data_q <= out_data_d;
            tries_q    <= tries_d;
            fail_q     <= fail_d;
        end
    end

    assign cand       = lfsr_q;
    assign cand_valid = (state_q == ST_PROPOSE);
    assign out_valid  = (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = out_data_q;
    assign tries      = tries_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_split_sample_gen.sv
// Randomized scoreboard bench for split_sample_gen: a driver queues expected results from a
// golden LFSR sequence table, a negedge monitor checks every proposal and every result.
module tb_split_sample_gen;

    localparam int W    = 13;
    localparam int MAXT = 64;
    localparam int TAPV = 'h100D;
    localparam int SEEDV = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  cand;
    logic          cand_valid;
    logic          chk_sat;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          fail;
    logic          busy;
    logic [6:0]    tries;

    int            chk_mode = 0;
    logic [W-1:0]  sat_mask = '0;
    logic [W-1:0]  sat_pat  = '0;

    typedef struct {
        bit   is_fail;
        int   data;
        int   tries;
        int   idx0;
    } exp_t;

    exp_t sb[$];
    int   seq[8192];
    int   period;
    int   idx = 0;
    int   prop_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    split_sample_gen dut (
        .clk(clk), .rst(rst), .start(start), .cand(cand), .cand_valid(cand_valid),
        .chk_sat(chk_sat), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fail(fail), .busy(busy), .tries(tries)
    );

    always #5 clk = ~clk;

    function automatic bit sat_fn(input int mode, input logic [W-1:0] m, input logic [W-1:0] p,
                                  input logic [W-1:0] v);
        case (mode)
            0:       return |(v | 13'h19de);
            1:       return v == 13'h0008;
            2:       return 1'b0;
            default: return (v & m) == p;
        endcase
    endfunction

    always_comb chk_sat = sat_fn(chk_mode, sat_mask, sat_pat, cand);

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Multiplication by x modulo x^13 + TAPS, done with plain integer arithmetic.
    function automatic int gold_next(input int v);
        int r;
        r = v * 2;
        if (r >= (1 << W)) r = r ^ ((1 << W) | TAPV);
        return r;
    endfunction

    function automatic exp_t model(input int mode, input logic [W-1:0] m, input logic [W-1:0] p,
                                   input int idx0);
        exp_t e;
        bit   found;
        e.idx0 = idx0; e.is_fail = 1'b1; e.tries = MAXT; e.data = 0;
        found = 1'b0;
        for (int k = 0; k < MAXT; k++) begin
            if (!found && sat_fn(mode, m, p, W'(seq[(idx0 + k) % period]))) begin
                found = 1'b1;
                e.is_fail = 1'b0;
                e.tries = k + 1;
                e.data = seq[(idx0 + k) % period];
            end
        end
        return e;
    endfunction

    // Monitor: checks every live proposal and every result against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prop_cnt = 0;
        end else begin
            if (cand_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_proposal", 1, 0);
                end else begin
                    chk("cand", int'(cand), seq[(sb[0].idx0 + prop_cnt) % period]);
                    chk("cand_nonzero", int'(cand != '0), 1);
                end
                prop_cnt++;
            end
            if (out_valid) begin
                if (sb.size() == 0 || sb[0].is_fail) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), sb[0].data);
                    if (out_ready) begin
                        chk("tries_ok", int'(tries), sb[0].tries);
                        chk("proposals_ok", prop_cnt, sb[0].tries);
                        void'(sb.pop_front());
                        prop_cnt = 0;
                    end
                end
            end
            if (fail) begin
                if (sb.size() == 0 || !sb[0].is_fail) begin
                    chk("unexpected_fail", 1, 0);
                end else begin
                    chk("tries_fail", int'(tries), MAXT);
                    chk("proposals_fail", prop_cnt, MAXT);
                    chk("busy_with_fail", int'(busy), 0);
                    void'(sb.pop_front());
                    prop_cnt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        sb.delete();
        idx = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cand_valid", int'(cand_valid), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tries", int'(tries), 0);
        chk("rst_cand", int'(cand), SEEDV);
    endtask

    // hold_mode: 0 none, 1 pulse start while held (delay>=1), 2 start together with out_ready
    task automatic run_req(input int mode, input logic [W-1:0] m, input logic [W-1:0] p,
                           input int delay, input int hold_mode);
        exp_t e;
        bit   done;
        @(posedge clk); #1;
        chk_mode = mode; sat_mask = m; sat_pat = p;
        e = model(mode, m, p, idx);
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int cyc = 1; cyc <= MAXT + 8 && !done; cyc++) begin
            @(negedge clk);
            if (out_valid || fail) begin
                done = 1'b1;
                chk("latency", cyc, e.tries + 1);
            end
        end
        if (!done) begin
            chk("timeout", 0, 1);
            do_reset();
            return;
        end
        if (out_valid) begin
            for (int d = 0; d < delay; d++) begin
                @(posedge clk); #1;
                start = (hold_mode == 1 && d == 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            start = (hold_mode == 2);
            @(posedge clk); #1;
            out_ready = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("idle_after_accept", int'(busy), 0);
            if (hold_mode != 0) begin
                @(negedge clk);
                chk("start_not_queued", int'(busy), 0);
            end
        end
        idx = (idx + e.tries) % period;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int kbits;
        int dly;
        int hm;
        logic [W-1:0] m;
        logic [W-1:0] p;

        seq[0] = SEEDV;
        period = 0;
        v = SEEDV;
        for (int i = 1; i <= 8191 && period == 0; i++) begin
            v = gold_next(v);
            if (v == SEEDV) period = i;
            else seq[i] = v;
        end
        if (period == 0) period = 8191;

        repeat (3) @(posedge clk);
        do_reset();

        // Always-true checker: first proposal accepted.
        run_req(0, '0, '0, 0, 0);

        // Accept only 0x0008 from a fresh seed, hold through 5 stalled cycles.
        do_reset();
        run_req(1, '0, '0, 5, 0);

        // Never satisfied: full MAX_TRIES then a fail pulse.
        run_req(2, '0, '0, 0, 0);

        // Reset in the middle of a proposal run.
        @(posedge clk); #1;
        chk_mode = 2;
        sb.push_back(model(2, '0, '0, idx));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_run_busy", int'(busy), 1);
        do_reset();
        run_req(0, '0, '0, 0, 0);

        // Back-to-back requests with start pulses while held.
        for (int i = 0; i < 8; i++) run_req(0, '0, '0, i % 3, (i % 3 == 0) ? 2 : 1);

        // Random masks/patterns, random stalls and start abuse.
        for (int i = 0; i < 60; i++) begin
            kbits = $urandom_range(1, 7);
            m = '0;
            for (int b = 0; b < kbits; b++) m[$urandom_range(0, W - 1)] = 1'b1;
            p = W'($urandom) & m;
            dly = $urandom_range(0, 3);
            hm = (dly > 0) ? $urandom_range(0, 1) : 2 * $urandom_range(0, 1);
            run_req(3, m, p, dly, hm);
        end

        // Long run: every request hands out the next sequence value.
        do_reset();
        for (int i = 0; i < 8191; i++) run_req(0, '0, '0, 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
